// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data requesters, data first with a fetch anti-starvation streak limit.
// Optional bus-timeout abort is compiled in with `define MEM_ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ack,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_err,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ack,
  output logic [XLEN-1:0] d_rdata,
  output logic            d_err,
  output logic            mem_enable,
  output logic            mem_r_w,
  output logic [XLEN-1:0] mem_address,
  output logic [XLEN-1:0] mem_input,
  input  logic [XLEN-1:0] mem_output,
  input  logic            mem_ready
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, DONE} state_t;
  state_t            state_q, state_d;
  logic [3:0]        streak_q, streak_d;
  logic              mem_enable_q, mem_enable_d, mem_r_w_q, mem_r_w_d;
  logic [XLEN-1:0]   mem_address_q, mem_address_d, mem_input_q, mem_input_d;
  logic [XLEN-1:0]   if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d, d_ack_q, d_ack_d;
  logic              busy, abort, grant_d;
  assign busy    = state_q == BUSY_I || state_q == BUSY_D;
  assign grant_d = d_req && (!if_req || streak_q != 4'(MAX_DATA_STREAK));
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  logic          if_err_q, d_err_q;
  // the counter holds the number of completed BUSY cycles, so the abort fires on the last one
  assign abort = busy && !mem_ready && tmo_q == TW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmo_q    <= '0;
      if_err_q <= 1'b0;
      d_err_q  <= 1'b0;
    end else begin
      tmo_q    <= busy ? tmo_q + TW'(1) : '0;
      if_err_q <= abort && state_q == BUSY_I;
      d_err_q  <= abort && state_q == BUSY_D;
    end
  end
  assign if_err = if_err_q;
  assign d_err  = d_err_q;
`else
  assign abort  = 1'b0;
  assign if_err = 1'b0;
  assign d_err  = 1'b0;
`endif
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    mem_enable_d  = mem_enable_q;
    mem_r_w_d     = mem_r_w_q;
    mem_address_d = mem_address_q;
    mem_input_d   = mem_input_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_ack_d      = 1'b0;
    d_ack_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d       = BUSY_D;
          mem_enable_d  = 1'b1;
          mem_r_w_d     = d_we;
          mem_address_d = d_addr;
          mem_input_d   = d_wdata;
          streak_d      = !if_req ? 4'd0 : streak_q == 4'(MAX_DATA_STREAK) ? streak_q : streak_q + 4'd1;
        end else if (if_req) begin
          state_d       = BUSY_I;
          mem_enable_d  = 1'b1;
          mem_r_w_d     = 1'b0;
          mem_address_d = if_addr;
          streak_d      = 4'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || abort) begin
          state_d      = DONE;
          mem_enable_d = 1'b0;
          if_ack_d     = state_q == BUSY_I;
          d_ack_d      = state_q == BUSY_D;
          if_rdata_d   = mem_ready && state_q == BUSY_I ? mem_output : if_rdata_q;
          d_rdata_d    = mem_ready && state_q == BUSY_D && !mem_r_w_q ? mem_output : d_rdata_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      streak_q      <= 4'd0;
      mem_enable_q  <= 1'b0;
      mem_r_w_q     <= 1'b0;
      mem_address_q <= '0;
      mem_input_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_ack_q      <= 1'b0;
      d_ack_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      streak_q      <= streak_d;
      mem_enable_q  <= mem_enable_d;
      mem_r_w_q     <= mem_r_w_d;
      mem_address_q <= mem_address_d;
      mem_input_q   <= mem_input_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_ack_q      <= if_ack_d;
      d_ack_q       <= d_ack_d;
    end
  end
  assign mem_enable  = mem_enable_q;
  assign mem_r_w     = mem_r_w_q;
  assign mem_address = mem_address_q;
  assign mem_input   = mem_input_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_ack      = if_ack_q;
  assign d_ack       = d_ack_q;
endmodule
